lane_pair_driver: RTL and testbench

Sequential driver for a lane-pair enable/acknowledge interface: walks a primary mask (`foo_o`) and a lagging secondary mask (`bar_o`) up to all-lanes-set, holds, then unwinds them in reverse. It is the producing end for the per-lane procedural concurrent check `foo[i] && bar[i]` used by the assertion tests. The block guarantees that check holds for every lane in HOLD, and that `bar_o` is always a subset of `foo_o`.

---
 rtl/lane_pair_pkg.sv | 20 ++
 rtl/lane_pair_driver.sv | 99 +++++++++
 tb/tb_lane_pair_driver.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_pair_pkg.sv
// Shared types and helpers for the lane-pair enable/acknowledge driver.
// lp_mask_ok is the subset check that benches reuse.
package lane_pair_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      HOLD,
      DRAIN
   } lp_state_e;

   localparam int LP_LANES_DEF = 10;
   localparam int LP_WIDTH_DEF = 11;

   function automatic logic lp_mask_ok(input logic [LP_WIDTH_DEF-1:0] foo,
                                       input logic [LP_WIDTH_DEF-1:0] bar);
      return (bar & ~foo) == '0;
   endfunction

endpackage

// File: rtl/lane_pair_driver.sv
// Walks foo_o up lane by lane with bar_o one edge behind, holds at all-set,
// then unwinds bar before foo so bar_o is always a subset of foo_o.
module lane_pair_driver
   import lane_pair_pkg::*;
#(
   parameter int LANES = LP_LANES_DEF,
   parameter int WIDTH = LP_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] foo_o,
   output logic [WIDTH-1:0] bar_o,
   output logic             busy_o,
   output logic             ready_o,
   output logic             done_o
);

   localparam int IW = $clog2(LANES + 1);
   localparam logic [IW-1:0] LAST = IW'(LANES);
   localparam logic [IW-1:0] ONE  = IW'(1);

   lp_state_e        state, state_nx;
   logic [IW-1:0]    idx, idx_nx;
   logic             clr_pend, clr_pend_nx;
   logic [WIDTH-1:0] foo_nx, bar_nx;

   function automatic logic [WIDTH-1:0] lane_bit(input logic [IW-1:0] n);
      return WIDTH'(1) << n;
   endfunction

   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      clr_pend_nx = clr_pend;
      foo_nx      = foo_o;
      bar_nx      = bar_o;
      case (state)
         IDLE: begin
            foo_nx      = '0;
            bar_nx      = '0;
            clr_pend_nx = 1'b0;
            // A clear arriving with start is dropped, not latched.
            if (start_i) begin
               foo_nx   = lane_bit('0);
               idx_nx   = ONE;
               state_nx = FILL;
            end
         end
         FILL: begin
            if (idx < LAST) foo_nx = foo_o | lane_bit(idx);
            bar_nx = bar_o | lane_bit(idx - ONE);
            if (clear_i) clr_pend_nx = 1'b1;
            if (idx == LAST) state_nx = HOLD;
            else             idx_nx   = idx + ONE;
         end
         HOLD: begin
            if (clear_i || clr_pend) begin
               bar_nx      = bar_o & ~lane_bit(LAST - ONE);
               idx_nx      = LAST - ONE;
               clr_pend_nx = 1'b0;
               state_nx    = DRAIN;
            end
         end
         DRAIN: begin
            // bar[idx-1] has to drop in the same edge as foo[idx] to keep the lag.
            foo_nx = foo_o & ~lane_bit(idx);
            if (idx != '0) bar_nx = bar_o & ~lane_bit(idx - ONE);
            if (idx == '0) state_nx = IDLE;
            else           idx_nx   = idx - ONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         clr_pend <= 1'b0;
         foo_o    <= '0;
         bar_o    <= '0;
         busy_o   <= 1'b0;
         ready_o  <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         clr_pend <= clr_pend_nx;
         foo_o    <= foo_nx;
         bar_o    <= bar_nx;
         busy_o   <= (state_nx != IDLE);
         ready_o  <= (state_nx == HOLD);
         done_o   <= (state == DRAIN) && (state_nx == IDLE);
      end
   end

endmodule

// File: tb/tb_lane_pair_driver.sv
// Directed bench for lane_pair_driver: default 10-lane instance plus a 1-lane instance.
module tb_lane_pair_driver;
   import lane_pair_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, clear = 1'b0;
   logic [10:0] foo, bar;
   logic        busy, ready, done;
   logic        start1 = 1'b0, clear1 = 1'b0;
   logic [10:0] foo1, bar1;
   logic        busy1, ready1, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lane_pair_driver #(.LANES(10), .WIDTH(11)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .clear_i(clear),
      .foo_o(foo), .bar_o(bar), .busy_o(busy), .ready_o(ready), .done_o(done));

   lane_pair_driver #(.LANES(1), .WIDTH(11)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .clear_i(clear1),
      .foo_o(foo1), .bar_o(bar1), .busy_o(busy1), .ready_o(ready1), .done_o(done1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; clear = 1'b1; start1 = 1'b1;
      tick(); tick();
      checks++;
      if ({foo, bar, busy, ready, done} !== 25'd0) begin
         errors++;
         $display("FAIL reset10: got foo=%h bar=%h b/r/d=%b%b%b expected all 0", foo, bar, busy, ready, done);
      end
      checks++;
      if ({foo1, bar1, busy1, ready1, done1} !== 25'd0) begin
         errors++;
         $display("FAIL reset1: got foo=%h bar=%h b/r/d=%b%b%b expected all 0", foo1, bar1, busy1, ready1, done1);
      end
      start = 1'b0; clear = 1'b0; start1 = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if ({foo, bar, busy} !== 23'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got foo=%h bar=%h busy=%b expected 0", foo, bar, busy);
      end
   endtask

   task automatic test_fill();
      logic [10:0] ef, eb;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (foo !== 11'h001 || bar !== 11'h000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL fill_e0: got foo=%h bar=%h busy=%b expected 001 000 1", foo, bar, busy);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         ef = (k < 10) ? 11'((32'd1 << (k + 1)) - 1) : 11'h3FF;
         eb = 11'((32'd1 << k) - 1);
         checks++;
         if (foo !== ef || bar !== eb || ready !== (k == 10)) begin
            errors++;
            $display("FAIL fill_e%0d: got foo=%h bar=%h ready=%b expected %h %h %b", k, foo, bar, ready, ef, eb, k == 10);
         end
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (!(foo[i] && bar[i])) begin
            errors++;
            $display("FAIL hold_lane%0d: got foo=%b bar=%b expected 1 1", i, foo[i], bar[i]);
         end
      end
      tick(); tick();
      checks++;
      if (ready !== 1'b1 || foo !== 11'h3FF || bar !== 11'h3FF) begin
         errors++;
         $display("FAIL hold_stays: got ready=%b foo=%h bar=%h expected 1 3ff 3ff", ready, foo, bar);
      end
   endtask

   task automatic test_drain();
      logic [10:0] ef, eb;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (foo !== 11'h3FF || bar !== 11'h1FF || ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drain_d0: got foo=%h bar=%h ready=%b busy=%b expected 3ff 1ff 0 1", foo, bar, ready, busy);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         ef = 11'((32'd1 << (10 - k)) - 1);
         eb = (k < 10) ? 11'((32'd1 << (9 - k)) - 1) : 11'h000;
         checks++;
         if (foo !== ef || bar !== eb || done !== (k == 10) || busy !== (k != 10)) begin
            errors++;
            $display("FAIL drain_d%0d: got foo=%h bar=%h done=%b busy=%b expected %h %h %b %b",
                     k, foo, bar, done, busy, ef, eb, k == 10, k != 10);
         end
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_clear_in_fill();
      int ready_cycles = 0;
      int wait_edges = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 5; k <= 10; k++) tick();
      checks++;
      if (ready !== 1'b1 || foo !== 11'h3FF || bar !== 11'h3FF) begin
         errors++;
         $display("FAIL pend_hold: got ready=%b foo=%h bar=%h expected 1 3ff 3ff", ready, foo, bar);
      end
      ready_cycles = 1;
      tick();
      if (ready) ready_cycles++;
      checks++;
      if (ready_cycles != 1 || foo !== 11'h3FF || bar !== 11'h1FF) begin
         errors++;
         $display("FAIL pend_drain_start: got ready_cycles=%0d foo=%h bar=%h expected 1 3ff 1ff", ready_cycles, foo, bar);
      end
      while (!done && wait_edges < 20) begin
         tick();
         wait_edges++;
      end
      checks++;
      if (wait_edges != 10 || foo !== 11'h000 || bar !== 11'h000) begin
         errors++;
         $display("FAIL pend_drain_len: got edges=%0d foo=%h bar=%h expected 10 000 000", wait_edges, foo, bar);
      end
      tick();
   endtask

   task automatic test_start_clear_idle();
      start = 1'b1; clear = 1'b1;
      tick();
      start = 1'b0; clear = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      tick(); tick();
      checks++;
      if (ready !== 1'b1 || foo !== 11'h3FF) begin
         errors++;
         $display("FAIL start_wins: got ready=%b foo=%h expected 1 3ff (clear dropped)", ready, foo);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL start_wins_drain: got done=%b expected 1", done);
      end
      tick();
   endtask

   task automatic test_reset_mid_drain();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (foo !== 11'h07F || bar !== 11'h03F) begin
         errors++;
         $display("FAIL mid_drain: got foo=%h bar=%h expected 07f 03f", foo, bar);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({foo, bar, busy, ready, done} !== 25'd0) begin
         errors++;
         $display("FAIL reset_mid_drain: got foo=%h bar=%h b/r/d=%b%b%b expected all 0", foo, bar, busy, ready, done);
      end
      tick();
      checks++;
      if ({foo, bar, busy} !== 23'd0) begin
         errors++;
         $display("FAIL reset_stays_idle: got foo=%h bar=%h busy=%b expected 0", foo, bar, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if (ready !== 1'b1 || foo !== 11'h3FF || bar !== 11'h3FF) begin
         errors++;
         $display("FAIL refill: got ready=%b foo=%h bar=%h expected 1 3ff 3ff", ready, foo, bar);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      int diff;
      int guard = 0;
      logic prev_done = 1'b0;
      start = 1'b1; clear = 1'b1;
      for (int c = 0; c < 80; c++) begin
         tick();
         diff = $countones(foo) - $countones(bar);
         checks++;
         if (!lp_mask_ok(foo, bar) || foo[10] !== 1'b0 || bar[10] !== 1'b0 || diff < 0 || diff > 1) begin
            errors++;
            $display("FAIL b2b_invariant c%0d: got foo=%h bar=%h expected bar subset, bit10=0, diff 0..1", c, foo, bar);
         end
         if (prev_done) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_no_dead_cycle c%0d: got busy=%b expected 1", c, busy);
            end
         end
         if (done) dones++;
         prev_done = done;
      end
      checks++;
      if (dones != 3) begin
         errors++;
         $display("FAIL b2b_rounds: got %0d done pulses expected 3", dones);
      end
      start = 1'b0; clear = 1'b0;
      while (busy && guard < 40) begin
         tick();
         guard++;
      end
      checks++;
      if (busy !== 1'b0 || foo !== 11'h000) begin
         errors++;
         $display("FAIL b2b_settle: got busy=%b foo=%h expected 0 000", busy, foo);
      end
   endtask

   task automatic test_lanes1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checks++;
      if (foo1 !== 11'h001 || bar1 !== 11'h000 || ready1 !== 1'b0 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL l1_fill0: got foo=%h bar=%h ready=%b busy=%b expected 001 000 0 1", foo1, bar1, ready1, busy1);
      end
      tick();
      checks++;
      if (foo1 !== 11'h001 || bar1 !== 11'h001 || ready1 !== 1'b1) begin
         errors++;
         $display("FAIL l1_hold: got foo=%h bar=%h ready=%b expected 001 001 1", foo1, bar1, ready1);
      end
      clear1 = 1'b1;
      tick();
      clear1 = 1'b0;
      checks++;
      if (foo1 !== 11'h001 || bar1 !== 11'h000 || ready1 !== 1'b0 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL l1_drain0: got foo=%h bar=%h ready=%b done=%b expected 001 000 0 0", foo1, bar1, ready1, done1);
      end
      tick();
      checks++;
      if (foo1 !== 11'h000 || bar1 !== 11'h000 || done1 !== 1'b1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL l1_done: got foo=%h bar=%h done=%b busy=%b expected 000 000 1 0", foo1, bar1, done1, busy1);
      end
      tick();
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("FAIL l1_done_pulse: got done=%b expected 0", done1);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_clear_in_fill();
      test_start_clear_idle();
      test_reset_mid_drain();
      test_back_to_back();
      test_lanes1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
